instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache.
- Responder on the fetch-side interface (IFIC_* in / ICIF_* out): serves the instruction fetcher's word requests.
- Refills on a miss from the memory controller over a word-serial interface (ICMC_* out / MCIC_* in).
- Hits are answered combinationally in the request cycle, so the fetcher can decode ICIF_data the same cycle.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- INDEX_WIDTH, 6, log2 of line count (64 lines).
- OFFSET_WIDTH, 4, log2 of line size in bytes (16 B = 4 words); must be >= 3.

Ports:
- Sys_clk  in  1  clock, rising edge.
- Sys_rst  in  1  reset; asynchronous, active-high.
- Sys_rdy  in  1  global enable; low = freeze all state.
- IFIC_en  in  1  fetch request; level, held until served.
- IFIC_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
- ICIF_en  out  1  hit/valid; combinational.
- ICIF_data  out  32  instruction word; 0 when ICIF_en=0.
- ICMC_en  out  1  line-fill request; registered level.
- ICMC_addr  out  ADDR_WIDTH  line-aligned fill address; registered.
- MCIC_en  in  1  one fill word valid this cycle.
- MCIC_data  in  32  fill word, delivered in ascending address order.

Behaviour:
- Address split: tag = [ADDR_WIDTH-1 : INDEX_WIDTH+OFFSET_WIDTH]; index = [INDEX_WIDTH+OFFSET_WIDTH-1 : OFFSET_WIDTH]; word = [OFFSET_WIDTH-1 : 2].
- WORDS = 2^(OFFSET_WIDTH-2).
- Storage:
  - valid bit per line;
  - tag array;
  - data array of WORDS x 32 per line.
- Reset (async, any state, including mid-fill):
  - all valid bits = 0; state = IDLE; ICMC_en = 0; ICMC_addr = 0; word counter = 0.
  - ICIF_en reads 0 while reset is asserted and afterwards until a line is valid.
  - Data/tag array contents are don't-care.
- States: IDLE, FILL.
- Hit definition: hit = IFIC_en && Sys_rdy && !Sys_rst && state==IDLE && valid[index] && tag match.
  - ICIF_en = hit.
  - ICIF_data = data[index][word] when hit, else 0.
  - Latency 0 cycles.
- IDLE -> FILL, on a clock edge where Sys_rdy && IFIC_en && !hit:
  - latch fill address {tag, index, OFFSET_WIDTH'b0} into ICMC_addr;
  - ICMC_en <= 1; counter <= 0; clear valid[index].
- FILL:
  - Each edge with Sys_rdy && MCIC_en: write MCIC_data to data[fill index][counter]; counter++.
  - On the edge accepting word WORDS-1: write tag, set valid; ICMC_en <= 0; ICMC_addr <= 0; counter <= 0; state <= IDLE.
  - ICIF_en = 0 throughout FILL, even if the requested address maps to another, valid line.
  - First hit on the refilled line occurs in the cycle after the last fill word.
- Address change during FILL (e.g. fetcher redirect after a misprediction): the fill of the latched line always completes. The new address is evaluated only after return to IDLE (hit or a new miss).
- IFIC_en dropped during FILL: the fill still completes; no other effect.
- MCIC_en in IDLE: ignored.
- Sys_rdy = 0: no state, counter, array or output register changes; MCIC_en ignored that cycle; ICIF_en forced 0. The memory controller is frozen by the same Sys_rdy.
- Replacement: direct-mapped; a miss evicts the resident line unconditionally. No write path, no flush input.
- ICMC_en transitions 0 -> 1 -> 0 exactly once per miss, and is never re-asserted in the edge that returns to IDLE.

Test Plan:
- Cold miss: reset, IFIC_en=1, addr 0x0 -> ICIF_en=0; next cycle ICMC_en=1, ICMC_addr=0x0. Memory returns 0x11,0x22,0x33,0x44 on four MCIC_en pulses -> ICMC_en=0 after the 4th; next cycle ICIF_en=1, ICIF_data=0x11.
- Same-line hits after that fill: addr 0x8 -> ICIF_data=0x33 the same cycle; addr 0xC -> 0x44; addr 0x10 -> miss, ICMC_addr=0x10.
- Conflict eviction: line 0x0 resident, request 0x400 (index 0, different tag) -> fill at 0x400. A later request to 0x0 misses again and refetches.
- Redirect mid-fill: miss on 0x20, switch IFIC_addr to 0x100 after the 2nd word -> 0x20 fill completes with all 4 words; then a new fill with ICMC_addr=0x100; a later request to 0x20 hits.
- Stall mid-fill: Sys_rdy=0 for 3 cycles between words 1 and 2 while MCIC_en pulses -> pulses ignored, counter holds; the fill completes correctly once Sys_rdy=1.
- Reset mid-fill: Sys_rst asserted after the 2nd fill word -> ICMC_en=0 immediately (async). After release, the same address misses and a full 4-word fill reissues.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hits toward the fetcher,
// word-serial line refill from the memory controller on a miss.
`timescale 1ns/1ps
module instruction_cache #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 6,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst,
  input  logic                  Sys_rdy,
  input  logic                  IFIC_en,
  input  logic [ADDR_WIDTH-1:0] IFIC_addr,
  output logic                  ICIF_en,
  output logic [31:0]           ICIF_data,
  output logic                  ICMC_en,
  output logic [ADDR_WIDTH-1:0] ICMC_addr,
  input  logic                  MCIC_en,
  input  logic [31:0]           MCIC_data
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int WORD_BITS = OFFSET_WIDTH - 2;
  localparam int WORDS     = 1 << WORD_BITS;
  localparam int LINES     = 1 << INDEX_WIDTH;

  // Handshake: ICMC_en stays high from the miss until the edge that accepts the last
  // word; a word transfers on every edge where Sys_rdy && MCIC_en while in FILL.
  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state, state_next;
  logic [LINES-1:0]       valid;
  logic [TAG_WIDTH-1:0]   tag_mem  [LINES];
  logic [31:0]            data_mem [LINES*WORDS];
  logic [WORD_BITS-1:0]   count;

  logic [TAG_WIDTH-1:0]   req_tag, fill_tag;
  logic [INDEX_WIDTH-1:0] req_index, fill_index;
  logic [WORD_BITS-1:0]   req_word;
  logic                   hit, start_fill, accept, last;
  logic                   unused_bits;

  assign req_tag    = IFIC_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign req_index  = IFIC_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_word   = IFIC_addr[2 +: WORD_BITS];
  assign fill_tag   = ICMC_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign fill_index = ICMC_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign unused_bits = ^{IFIC_addr[1:0], ICMC_addr[OFFSET_WIDTH-1:0]};

  assign hit = IFIC_en && Sys_rdy && !Sys_rst && (state == IDLE) &&
               valid[req_index] && (tag_mem[req_index] == req_tag);

  assign ICIF_en   = hit;
  assign ICIF_data = hit ? data_mem[{req_index, req_word}] : 32'd0;

  always_comb begin
    state_next = state;
    start_fill = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (Sys_rdy && IFIC_en && !hit) begin
          start_fill = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (Sys_rdy && MCIC_en) begin
          accept = 1'b1;
          if (count == WORD_BITS'(WORDS - 1)) begin
            last       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The fill line stays addressed by ICMC_addr, so a fetcher redirect cannot disturb it.
  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      state     <= IDLE;
      valid     <= '0;
      ICMC_en   <= 1'b0;
      ICMC_addr <= '0;
      count     <= '0;
    end else begin
      state <= state_next;
      if (start_fill) begin
        ICMC_en           <= 1'b1;
        ICMC_addr         <= {IFIC_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
        count             <= '0;
        valid[req_index]  <= 1'b0;
      end
      if (accept) begin
        count <= count + 1'b1;
        if (last) begin
          valid[fill_index] <= 1'b1;
          ICMC_en           <= 1'b0;
          ICMC_addr         <= '0;
          count             <= '0;
        end
      end
    end
  end

  always_ff @(posedge Sys_clk) begin
    if (accept) data_mem[{fill_index, count}] <= MCIC_data;
    if (last)   tag_mem[fill_index]           <= fill_tag;
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed scenarios plus randomized traffic, checked every
// cycle against a line-level cache model that tracks resident line addresses and words.
`timescale 1ns/1ps
module tb_instruction_cache;

  logic        Sys_clk = 1'b0;
  logic        Sys_rst = 1'b1;
  logic        Sys_rdy = 1'b1;
  logic        IFIC_en = 1'b0;
  logic [31:0] IFIC_addr = 32'd0;
  logic        MCIC_en = 1'b0;
  logic [31:0] MCIC_data = 32'd0;
  logic        ICIF_en, ICMC_en;
  logic [31:0] ICIF_data, ICMC_addr;

  int checks = 0;
  int failures = 0;
  bit check_on = 1'b0;
  bit mc_force = 1'b0;

  // Model: which line address each slot holds, its words, and the fill in flight.
  bit          m_valid [64];
  logic [27:0] m_line  [64];
  logic [31:0] m_words [64][4];
  bit          m_filling;
  logic [31:0] m_fill_addr;
  logic [31:0] fill_q[$];

  instruction_cache dut (
    .Sys_clk(Sys_clk), .Sys_rst(Sys_rst), .Sys_rdy(Sys_rdy),
    .IFIC_en(IFIC_en), .IFIC_addr(IFIC_addr),
    .ICIF_en(ICIF_en), .ICIF_data(ICIF_data),
    .ICMC_en(ICMC_en), .ICMC_addr(ICMC_addr),
    .MCIC_en(MCIC_en), .MCIC_data(MCIC_data)
  );

  initial forever #5 Sys_clk = ~Sys_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'h10) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[9:4]] && (m_line[a[9:4]] == a[31:4]);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_filling = 1'b0;
    m_fill_addr = 32'd0;
    fill_q.delete();
  endtask

  // Applies the rules of one clock edge using the inputs that were held across it.
  task automatic model_edge();
    logic [5:0] idx;
    if (Sys_rst) begin
      model_reset();
    end else if (Sys_rdy) begin
      if (!m_filling) begin
        if (IFIC_en && !m_hit(IFIC_addr)) begin
          m_filling   = 1'b1;
          m_fill_addr = {IFIC_addr[31:4], 4'h0};
          fill_q.delete();
          m_valid[IFIC_addr[9:4]] = 1'b0;
        end
      end else if (MCIC_en) begin
        fill_q.push_back(MCIC_data);
        if (fill_q.size() == 4) begin
          idx = m_fill_addr[9:4];
          for (int i = 0; i < 4; i++) m_words[idx][i] = fill_q[i];
          m_line[idx]  = m_fill_addr[31:4];
          m_valid[idx] = 1'b1;
          m_filling    = 1'b0;
          fill_q.delete();
        end
      end
    end
  endtask

  // Memory controller: serves the pending line in order with random gaps, and throws
  // stray pulses while idle.
  task automatic drive_mc();
    if (mc_force) begin
      MCIC_en   = 1'b1;
      MCIC_data = $urandom;
    end else if (m_filling) begin
      MCIC_en   = ($urandom_range(0, 3) != 0);
      MCIC_data = mem_word(m_fill_addr + 32'(fill_q.size() * 4));
    end else begin
      MCIC_en   = ($urandom_range(0, 5) == 0);
      MCIC_data = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge Sys_clk);
    #1;
    model_edge();
    drive_mc();
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_words(input string name, input int n);
    int i;
    for (i = 0; i < 200 && m_filling && fill_q.size() < n; i++) tick();
    check(name, 32'(i < 200), 32'd1);
  endtask

  task automatic wait_fill(input string name);
    int i;
    for (i = 0; i < 200 && m_filling; i++) tick();
    check(name, 32'(m_filling), 32'd0);
  endtask

  always @(negedge Sys_clk) begin
    logic        exp_en;
    logic [31:0] exp_data;
    if (check_on) begin
      exp_en   = IFIC_en && Sys_rdy && !Sys_rst && !m_filling && m_hit(IFIC_addr);
      exp_data = exp_en ? m_words[IFIC_addr[9:4]][IFIC_addr[3:2]] : 32'd0;
      check("cyc_icif_en", 32'(ICIF_en), 32'(exp_en));
      check("cyc_icif_data", ICIF_data, exp_data);
      check("cyc_icmc_en", 32'(ICMC_en), 32'(m_filling));
      check("cyc_icmc_addr", ICMC_addr, m_filling ? m_fill_addr : 32'd0);
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    model_reset();
    IFIC_en = 1'b1;
    tick();
    check_on = 1'b1;
    tick();
    settle();
    check("rst_icif_en", 32'(ICIF_en), 32'd0);
    check("rst_icmc_en", 32'(ICMC_en), 32'd0);
    check("rst_icmc_addr", ICMC_addr, 32'd0);
    Sys_rst = 1'b0;

    // Cold miss on line 0.
    IFIC_addr = 32'h0;
    settle();
    check("cold_miss_en", 32'(ICIF_en), 32'd0);
    tick(); settle();
    check("cold_icmc_en", 32'(ICMC_en), 32'd1);
    check("cold_icmc_addr", ICMC_addr, 32'h0);
    wait_fill("cold_fill_done");
    settle();
    check("cold_icmc_low", 32'(ICMC_en), 32'd0);
    check("cold_hit_en", 32'(ICIF_en), 32'd1);
    check("cold_hit_data", ICIF_data, 32'h11);

    // Same-line hits, then the neighbouring line misses.
    IFIC_addr = 32'h8; settle();
    check("hit_8_data", ICIF_data, 32'h33);
    IFIC_addr = 32'hC; settle();
    check("hit_c_data", ICIF_data, 32'h44);
    IFIC_addr = 32'h10; settle();
    check("miss_10_en", 32'(ICIF_en), 32'd0);
    tick(); settle();
    check("miss_10_addr", ICMC_addr, 32'h10);
    wait_fill("fill_10_done");

    // Conflict eviction of line 0 by 0x400, then refetch of 0x0.
    IFIC_addr = 32'h400;
    tick(); settle();
    check("conf_400_addr", ICMC_addr, 32'h400);
    wait_fill("fill_400_done");
    IFIC_addr = 32'h0; settle();
    check("evicted_0_en", 32'(ICIF_en), 32'd0);
    tick(); settle();
    check("refetch_0_addr", ICMC_addr, 32'h0);
    wait_fill("refetch_0_done");
    settle();
    check("refetch_0_data", ICIF_data, 32'h11);

    // Redirect after the second word of a fill.
    IFIC_addr = 32'h20;
    tick();
    wait_words("redir_words", 2);
    IFIC_addr = 32'h100;
    wait_fill("redir_20_done");
    settle();
    check("redir_100_miss", 32'(ICIF_en), 32'd0);
    tick(); settle();
    check("redir_100_addr", ICMC_addr, 32'h100);
    wait_fill("redir_100_done");
    IFIC_addr = 32'h24; settle();
    check("redir_20_hit", 32'(ICIF_en), 32'd1);
    check("redir_20_data", ICIF_data, mem_word(32'h24));

    // Stall for three cycles mid-fill with the controller pulsing.
    IFIC_addr = 32'h40;
    tick();
    wait_words("stall_words", 2);
    Sys_rdy = 1'b0; mc_force = 1'b1; MCIC_en = 1'b1;
    settle();
    check("stall_icif_en", 32'(ICIF_en), 32'd0);
    repeat (3) tick();
    settle();
    check("stall_icmc_en", 32'(ICMC_en), 32'd1);
    Sys_rdy = 1'b1; mc_force = 1'b0;
    drive_mc();
    wait_fill("stall_fill_done");
    IFIC_addr = 32'h48; settle();
    check("stall_data_w2", ICIF_data, mem_word(32'h48));

    // Asynchronous reset in the middle of a fill.
    IFIC_addr = 32'h80;
    tick();
    wait_words("mrst_words", 2);
    #2;
    Sys_rst = 1'b1;
    model_reset();
    #1;
    check("mrst_icmc_en", 32'(ICMC_en), 32'd0);
    check("mrst_icmc_addr", ICMC_addr, 32'h0);
    tick(); tick();
    Sys_rst = 1'b0;
    settle();
    check("mrst_miss_en", 32'(ICIF_en), 32'd0);
    tick(); settle();
    check("mrst_refill_addr", ICMC_addr, 32'h80);
    wait_fill("mrst_fill_done");
    settle();
    check("mrst_hit_data", ICIF_data, mem_word(32'h80));

    // Randomized traffic over a small footprint so hits, conflicts and redirects mix.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        IFIC_en   = ($urandom_range(0, 4) != 0);
        IFIC_addr = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) |
                    $urandom_range(0, 15);
      end
      Sys_rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 599) == 0) begin
        Sys_rst = 1'b1;
        model_reset();
        tick();
        Sys_rst = 1'b0;
      end
      tick();
    end

    check_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
